inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/fetch_pkg.sv | 16 +
 rtl/inst_queue.sv | 53 +++++
 rtl/inst_fetch.sv | 98 +++++++++
 tb/tb_inst_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared instruction-fetch types and constants.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } iq_entry_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular instruction queue: head/tail pointers, occupancy count, push/pop/flush.
module inst_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  iq_entry_t                push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output iq_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    iq_entry_t         mem [DEPTH];
    logic [PW-1:0]     head_ptr;
    logic [PW-1:0]     tail_ptr;
    logic              pop_ok;

    assign pop_ok = pop && (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push)   tail_ptr <= tail_ptr + 1'b1;
            if (pop_ok) head_ptr <= head_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: the head is masked to a NOP whenever count is zero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail_ptr] <= push_entry;
    end

    always_comb begin
        head = '{pc: '0, inst: INST_NOP};
        if (count != '0) head = mem[head_ptr];
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential PC, 1-cycle imem, small instruction queue, redirect flush.
// Optional macro INST_FETCH_MISALIGN_EN: misaligned redirect targets halt fetch via fetch_err.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        nxt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr_q;
    logic          inflight;
    logic          err;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occ;
    logic [CW-1:0] count;
    logic [31:0]   redirect_tgt;
    iq_entry_t     head;
    iq_entry_t     resp_entry;

    assign inst_valid   = (count != '0);
    assign pop          = nxt && inst_valid;
    assign push         = inflight && !redirect;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    // Slots already committed (queued + in flight) minus the one leaving this cycle.
    assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue = rst && !redirect && !err && (occ < (CW+1)'(IQ_DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign resp_entry = '{pc: req_addr_q, inst: imem_rdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            req_addr_q <= '0;
            inflight   <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_tgt;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_addr_q <= fetch_pc;
                fetch_pc   <= pc_next(fetch_pc);
            end
        end
    end

`ifdef INST_FETCH_MISALIGN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          err <= 1'b0;
        else if (redirect) err <= |redirect_pc[1:0];
    end
`else
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^redirect_pc[1:0];
    assign err = 1'b0;
`endif

    assign fetch_err = err;

    inst_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (resp_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .count      (count)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: queue-level reference model plus directed literal checks.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        nxt = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .IQ_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .nxt         (nxt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_err   (fetch_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    // Instruction memory: one-cycle read latency, garbage when not addressed.
    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {pc, inst} plus the one outstanding request.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc      = 32'h0;
    bit          m_inf     = 1'b0;
    logic [31:0] m_inf_pc  = 32'h0;
    bit          m_err     = 1'b0;

    task automatic model_cycle();
        bit   valid, pop, ereq;
        int   occ;
        ent_t e;
        if (!rst) begin
            mq.delete();
            m_pc  = 32'h0;
            m_inf = 1'b0;
            m_err = 1'b0;
            check("rst_valid", 32'(inst_valid), 32'd0);
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_err", 32'(fetch_err), 32'd0);
            return;
        end
        valid = (mq.size() != 0);
        pop   = nxt && valid;
        occ   = mq.size() + int'(m_inf) - int'(pop);
        ereq  = !redirect && !m_err && (occ < 2);
        check("m_valid", 32'(inst_valid), 32'(valid));
        check("m_inst", inst, valid ? mq[0].inst : 32'h0000_0013);
        check("m_inst_pc", inst_pc, valid ? mq[0].pc : 32'h0);
        check("m_req", 32'(imem_req), 32'(ereq));
        if (ereq) check("m_addr", imem_addr, m_pc);
        check("m_err", 32'(fetch_err), 32'(m_err));
        if (redirect) begin
            mq.delete();
            m_inf = 1'b0;
            m_pc  = {redirect_pc[31:2], 2'b00};
`ifdef INST_FETCH_MISALIGN_EN
            m_err = (redirect_pc[1:0] != 2'b00);
`endif
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_inf) begin
                e.pc   = m_inf_pc;
                e.inst = mem_word(m_inf_pc);
                mq.push_back(e);
            end
            m_inf = ereq;
            if (ereq) begin
                m_inf_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            model_cycle();
        end
    end

    initial begin
        logic [15:0] pat;
        pat = 16'b1011_0011_1000_1101;

        // Reset held
        repeat (3) @(negedge clk);
        #3;
        check("rst_hold_req", 32'(imem_req), 32'd0);
        check("rst_hold_valid", 32'(inst_valid), 32'd0);
        check("rst_hold_inst", inst, 32'h0000_0013);

        // Release with nxt high: streaming from 0
        @(negedge clk); rst = 1'b1; nxt = 1'b1;
        #3;
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        @(negedge clk); #3;
        check("c1_valid", 32'(inst_valid), 32'd0);
        check("c1_addr", imem_addr, 32'h4);
        @(negedge clk); #3;
        check("c2_valid", 32'(inst_valid), 32'd1);
        check("c2_pc", inst_pc, 32'h0);
        check("c2_req", 32'(imem_req), 32'd1);
        @(negedge clk); #3;
        check("c3_pc", inst_pc, 32'h4);
        check("c3_req", 32'(imem_req), 32'd1);
        @(negedge clk); #3;
        check("c4_pc", inst_pc, 32'h8);

        // Reset mid-stream with a response pending, then hold with nxt low
        @(negedge clk); rst = 1'b0; nxt = 1'b0;
        #3;
        check("midrst_valid", 32'(inst_valid), 32'd0);
        check("midrst_req", 32'(imem_req), 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (5) @(negedge clk);
        #3;
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_valid", 32'(inst_valid), 32'd1);
        check("hold_pc", inst_pc, 32'h0);
        @(negedge clk); nxt = 1'b1;
        #3;
        check("rel_pc0", inst_pc, 32'h0);
        @(negedge clk); #3;
        check("rel_pc1", inst_pc, 32'h4);

        // Refill to full, then redirect with nxt high
        @(negedge clk); nxt = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("full_req", 32'(imem_req), 32'd0);
        check("full_pc", inst_pc, 32'h8);
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h100; nxt = 1'b1;
        #3;
        check("redir_req", 32'(imem_req), 32'd0);
        @(negedge clk); redirect = 1'b0;
        #3;
        check("redir_valid0", 32'(inst_valid), 32'd0);
        check("redir_addr0", imem_addr, 32'h100);
        @(negedge clk); #3;
        check("redir_valid1", 32'(inst_valid), 32'd0);
        @(negedge clk); #3;
        check("redir_valid2", 32'(inst_valid), 32'd1);
        check("redir_pc", inst_pc, 32'h100);

        // Address wrap at the top of memory
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk); redirect = 1'b0;
        #3;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk); #3;
        check("wrap_addr1", imem_addr, 32'h0);
        check("wrap_req1", 32'(imem_req), 32'd1);
        @(negedge clk); #3;
        check("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
        @(negedge clk); #3;
        check("wrap_pc1", inst_pc, 32'h0);

        // Misaligned redirect target
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h102;
        @(negedge clk); redirect = 1'b0;
        #3;
`ifdef INST_FETCH_MISALIGN_EN
        check("mis_err", 32'(fetch_err), 32'd1);
        check("mis_req", 32'(imem_req), 32'd0);
        repeat (2) @(negedge clk);
        #3;
        check("mis_req_hold", 32'(imem_req), 32'd0);
        check("mis_valid_hold", 32'(inst_valid), 32'd0);
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk); redirect = 1'b0;
        #3;
        check("mis_clr_err", 32'(fetch_err), 32'd0);
        check("mis_clr_addr", imem_addr, 32'h200);
        repeat (2) @(negedge clk);
        #3;
        check("mis_clr_pc", inst_pc, 32'h200);
`else
        check("mis_err_tied", 32'(fetch_err), 32'd0);
        check("mis_addr_forced", imem_addr, 32'h100);
        repeat (2) @(negedge clk);
        #3;
        check("mis_pc_forced", inst_pc, 32'h100);
`endif

        // Irregular consume pattern, model-checked every cycle
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            nxt = pat[i];
        end
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h0000_0400; nxt = 1'b1;
        @(negedge clk); redirect = 1'b0;
        repeat (6) @(negedge clk);
        #3;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
